slc3_control_fsm: RTL and testbench

- Instruction-sequencing control unit (ISDU) for the SLC-3 datapath.
- Moore FSM: fetch, decode, execute for ADD, AND, NOT, BR, JMP, JSR, LDR, STR and optional PAUSE.
- Drives every load/gate/mux select and the memory strobes.
- Holds memory-access states for a parameterised number of cycles via an internal wait counter.

---
 rtl/slc3_control_fsm_pkg.sv | 40 ++++
 rtl/slc3_control_fsm_if.sv | 26 ++
 rtl/slc3_control_fsm_wait_ctr.sv | 24 ++
 rtl/slc3_control_fsm.sv | 169 ++++++++++++++++
 tb/tb_slc3_control_fsm.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/slc3_control_fsm_pkg.sv
// Shared types for the SLC-3 control unit: state enum, opcodes and mux/ALU encodings.
package slc3_ctrl_pkg;

    typedef enum logic [4:0] {
        S_HALTED, S_18, S_33, S_35, S_32,
        S_01, S_05, S_09, S_00, S_22,
        S_12, S_04, S_21, S_20,
        S_06, S_25, S_27,
        S_07, S_23, S_16,
        S_PAUSE1, S_PAUSE2
    } state_t;

    localparam logic [3:0] OP_BR    = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_JSR   = 4'b0100;
    localparam logic [3:0] OP_AND   = 4'b0101;
    localparam logic [3:0] OP_LDR   = 4'b0110;
    localparam logic [3:0] OP_STR   = 4'b0111;
    localparam logic [3:0] OP_NOT   = 4'b1001;
    localparam logic [3:0] OP_JMP   = 4'b1100;
    localparam logic [3:0] OP_PAUSE = 4'b1101;

    localparam logic [1:0] PCMUX_PC1   = 2'b00;
    localparam logic [1:0] PCMUX_ADDER = 2'b10;

    localparam logic [1:0] ADDR2_ZERO   = 2'b00;
    localparam logic [1:0] ADDR2_SEXT6  = 2'b01;
    localparam logic [1:0] ADDR2_SEXT9  = 2'b10;
    localparam logic [1:0] ADDR2_SEXT11 = 2'b11;

    localparam logic [1:0] ALUK_ADD   = 2'b00;
    localparam logic [1:0] ALUK_AND   = 2'b01;
    localparam logic [1:0] ALUK_NOT   = 2'b10;
    localparam logic [1:0] ALUK_PASSA = 2'b11;

    function automatic logic is_mem_wait(state_t s);
        return (s == S_33) || (s == S_25) || (s == S_16);
    endfunction

endpackage

// File: rtl/slc3_control_fsm_if.sv
// Control bundle between the SLC-3 sequencer (master) and the datapath (slave).
interface slc3_control_fsm_if;
    logic       Run, Continue, IR_5, IR_11, BEN;
    logic [3:0] Opcode;
    logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
    logic       GatePC, GateMDR, GateALU, GateMARMUX;
    logic [1:0] PCMUX, ADDR2MUX, ALUK;
    logic       DR, SR1MUX, SR2MUX, ADDR1MUX;
    logic       MIO_EN, Mem_OE, Mem_WE;

    modport master (
        input  Run, Continue, Opcode, IR_5, IR_11, BEN,
        output LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
               GatePC, GateMDR, GateALU, GateMARMUX,
               PCMUX, DR, SR1MUX, SR2MUX, ADDR1MUX, ADDR2MUX, ALUK,
               MIO_EN, Mem_OE, Mem_WE
    );

    modport slave (
        output Run, Continue, Opcode, IR_5, IR_11, BEN,
        input  LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
               GatePC, GateMDR, GateALU, GateMARMUX,
               PCMUX, DR, SR1MUX, SR2MUX, ADDR1MUX, ADDR2MUX, ALUK,
               MIO_EN, Mem_OE, Mem_WE
    );
endinterface

// File: rtl/slc3_control_fsm_wait_ctr.sv
// Memory-access hold counter: done flags the last cycle of a MEM_WAIT-long access.
module slc3_wait_ctr #(
    parameter int MEM_WAIT = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic done_o
);

    logic [3:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset || clr_i) begin
            cnt_q <= 4'd0;
        end else if (en_i) begin
            cnt_q <= cnt_q + 4'd1;
        end
    end

    assign done_o = (cnt_q == 4'(MEM_WAIT - 1));

endmodule

// File: rtl/slc3_control_fsm.sv
// SLC-3 instruction sequencer (Moore FSM). Define SLC3_PAUSE_EN to enable the PAUSE opcode.
module slc3_control_fsm
    import slc3_ctrl_pkg::*;
#(
    parameter int MEM_WAIT = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    slc3_control_fsm_if.master   ctrl
);

    state_t state_q, state_d;
    logic   waitDone;

    // The counter sits at zero outside memory states, so every entry starts a fresh hold.
    slc3_wait_ctr #(.MEM_WAIT(MEM_WAIT)) u_wait (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (!is_mem_wait(state_q)),
        .en_i   (is_mem_wait(state_q)),
        .done_o (waitDone)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_HALTED;
        else       state_q <= state_d;
    end

`ifndef SLC3_PAUSE_EN
    logic unused_continue;
    assign unused_continue = ctrl.Continue;
`endif

    always_comb begin
        state_d          = state_q;
        ctrl.LD_MAR      = 1'b0;
        ctrl.LD_MDR      = 1'b0;
        ctrl.LD_IR       = 1'b0;
        ctrl.LD_BEN      = 1'b0;
        ctrl.LD_CC       = 1'b0;
        ctrl.LD_REG      = 1'b0;
        ctrl.LD_PC       = 1'b0;
        ctrl.LD_LED      = 1'b0;
        ctrl.GatePC      = 1'b0;
        ctrl.GateMDR     = 1'b0;
        ctrl.GateALU     = 1'b0;
        ctrl.GateMARMUX  = 1'b0;
        ctrl.PCMUX       = PCMUX_PC1;
        ctrl.DR          = 1'b0;
        ctrl.SR1MUX      = 1'b0;
        ctrl.SR2MUX      = 1'b0;
        ctrl.ADDR1MUX    = 1'b0;
        ctrl.ADDR2MUX    = ADDR2_ZERO;
        ctrl.ALUK        = ALUK_ADD;
        ctrl.MIO_EN      = 1'b0;
        ctrl.Mem_OE      = 1'b0;
        ctrl.Mem_WE      = 1'b0;

        case (state_q)
            S_HALTED: if (ctrl.Run) state_d = S_18;
            S_18: begin
                ctrl.GatePC = 1'b1;
                ctrl.LD_MAR = 1'b1;
                ctrl.LD_PC  = 1'b1;
                state_d     = S_33;
            end
            S_33, S_25: begin
                ctrl.Mem_OE = 1'b1;
                ctrl.MIO_EN = 1'b1;
                ctrl.LD_MDR = 1'b1;
                if (waitDone) state_d = (state_q == S_33) ? S_35 : S_27;
            end
            S_35: begin
                ctrl.GateMDR = 1'b1;
                ctrl.LD_IR   = 1'b1;
                state_d      = S_32;
            end
            S_32: begin
                ctrl.LD_BEN = 1'b1;
                case (ctrl.Opcode)
                    OP_ADD:   state_d = S_01;
                    OP_AND:   state_d = S_05;
                    OP_NOT:   state_d = S_09;
                    OP_BR:    state_d = S_00;
                    OP_JMP:   state_d = S_12;
                    OP_JSR:   state_d = S_04;
                    OP_LDR:   state_d = S_06;
                    OP_STR:   state_d = S_07;
`ifdef SLC3_PAUSE_EN
                    OP_PAUSE: state_d = S_PAUSE1;
`endif
                    default:  state_d = S_18;
                endcase
            end
            S_01, S_05, S_09: begin
                ctrl.SR1MUX  = 1'b1;
                ctrl.SR2MUX  = (state_q == S_09) ? 1'b0 : ctrl.IR_5;
                ctrl.ALUK    = (state_q == S_01) ? ALUK_ADD :
                               (state_q == S_05) ? ALUK_AND : ALUK_NOT;
                ctrl.GateALU = 1'b1;
                ctrl.LD_REG  = 1'b1;
                ctrl.LD_CC   = 1'b1;
                state_d      = S_18;
            end
            S_00: state_d = ctrl.BEN ? S_22 : S_18;
            S_22: begin
                ctrl.ADDR2MUX = ADDR2_SEXT9;
                ctrl.PCMUX    = PCMUX_ADDER;
                ctrl.LD_PC    = 1'b1;
                state_d       = S_18;
            end
            S_12, S_20: begin
                ctrl.SR1MUX   = 1'b1;
                ctrl.ADDR1MUX = 1'b1;
                ctrl.PCMUX    = PCMUX_ADDER;
                ctrl.LD_PC    = 1'b1;
                state_d       = S_18;
            end
            S_04: begin
                ctrl.GatePC = 1'b1;
                ctrl.DR     = 1'b1;
                ctrl.LD_REG = 1'b1;
                state_d     = ctrl.IR_11 ? S_21 : S_20;
            end
            S_21: begin
                ctrl.ADDR2MUX = ADDR2_SEXT11;
                ctrl.PCMUX    = PCMUX_ADDER;
                ctrl.LD_PC    = 1'b1;
                state_d       = S_18;
            end
            S_06, S_07: begin
                ctrl.SR1MUX     = 1'b1;
                ctrl.ADDR1MUX   = 1'b1;
                ctrl.ADDR2MUX   = ADDR2_SEXT6;
                ctrl.GateMARMUX = 1'b1;
                ctrl.LD_MAR     = 1'b1;
                state_d         = (state_q == S_06) ? S_25 : S_23;
            end
            S_27: begin
                ctrl.GateMDR = 1'b1;
                ctrl.LD_REG  = 1'b1;
                ctrl.LD_CC   = 1'b1;
                state_d      = S_18;
            end
            S_23: begin
                ctrl.ALUK    = ALUK_PASSA;
                ctrl.GateALU = 1'b1;
                ctrl.LD_MDR  = 1'b1;
                state_d      = S_16;
            end
            S_16: begin
                ctrl.Mem_WE = 1'b1;
                if (waitDone) state_d = S_18;
            end
`ifdef SLC3_PAUSE_EN
            S_PAUSE1: begin
                ctrl.LD_LED = 1'b1;
                if (ctrl.Continue) state_d = S_PAUSE2;
            end
            S_PAUSE2: begin
                ctrl.LD_LED = 1'b1;
                if (!ctrl.Continue) state_d = S_18;
            end
`endif
            default: state_d = S_HALTED;
        endcase
    end

endmodule

// File: tb/tb_slc3_control_fsm.sv
// Bench for slc3_control_fsm: two instances (MEM_WAIT 2 and 3) against a queue-based micro-step model.
module tb_slc3_control_fsm;

    typedef struct packed {
        logic       ldMar, ldMdr, ldIr, ldBen, ldCc, ldReg, ldPc, ldLed;
        logic       gatePc, gateMdr, gateAlu, gateMarmux;
        logic [1:0] pcmux;
        logic       dr, sr1mux, sr2mux, addr1mux;
        logic [1:0] addr2mux, aluk;
        logic       mioEn, memOe, memWe;
    } ctl_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0, cont = 1'b0, ir5 = 1'b0, ir11 = 1'b0, ben = 1'b0;
    logic [3:0] opc = 4'hF;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    slc3_control_fsm_if ifA ();
    slc3_control_fsm_if ifB ();

    assign ifA.Run = run;  assign ifA.Continue = cont; assign ifA.Opcode = opc;
    assign ifA.IR_5 = ir5; assign ifA.IR_11 = ir11;    assign ifA.BEN = ben;
    assign ifB.Run = run;  assign ifB.Continue = cont; assign ifB.Opcode = opc;
    assign ifB.IR_5 = ir5; assign ifB.IR_11 = ir11;    assign ifB.BEN = ben;

    slc3_control_fsm #(.MEM_WAIT(2)) dutA (.clk(clk), .reset(rst), .ctrl(ifA));
    slc3_control_fsm #(.MEM_WAIT(3)) dutB (.clk(clk), .reset(rst), .ctrl(ifB));

    ctl_t obsA, obsB;
    assign obsA = {ifA.LD_MAR, ifA.LD_MDR, ifA.LD_IR, ifA.LD_BEN, ifA.LD_CC, ifA.LD_REG,
                   ifA.LD_PC, ifA.LD_LED, ifA.GatePC, ifA.GateMDR, ifA.GateALU, ifA.GateMARMUX,
                   ifA.PCMUX, ifA.DR, ifA.SR1MUX, ifA.SR2MUX, ifA.ADDR1MUX, ifA.ADDR2MUX,
                   ifA.ALUK, ifA.MIO_EN, ifA.Mem_OE, ifA.Mem_WE};
    assign obsB = {ifB.LD_MAR, ifB.LD_MDR, ifB.LD_IR, ifB.LD_BEN, ifB.LD_CC, ifB.LD_REG,
                   ifB.LD_PC, ifB.LD_LED, ifB.GatePC, ifB.GateMDR, ifB.GateALU, ifB.GateMARMUX,
                   ifB.PCMUX, ifB.DR, ifB.SR1MUX, ifB.SR2MUX, ifB.ADDR1MUX, ifB.ADDR2MUX,
                   ifB.ALUK, ifB.MIO_EN, ifB.Mem_OE, ifB.Mem_WE};

    // Model state is the textbook state number (-1 halted, 100/101 pause); queued steps follow.
    int cur [2];
    int pend0 [$];
    int pend1 [$];

    function automatic void pushQ(int k, int s);
        if (k == 0) pend0.push_back(s); else pend1.push_back(s);
    endfunction

    function automatic int popQ(int k);
        return (k == 0) ? pend0.pop_front() : pend1.pop_front();
    endfunction

    function automatic int sizeQ(int k);
        return (k == 0) ? pend0.size() : pend1.size();
    endfunction

    function automatic logic pauseEnabled();
`ifdef SLC3_PAUSE_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic ctl_t expOut(int s, logic irBit5);
        ctl_t c;
        c = '0;
        case (s)
            18:       begin c.gatePc = 1; c.ldMar = 1; c.ldPc = 1; end
            33, 25:   begin c.memOe = 1; c.mioEn = 1; c.ldMdr = 1; end
            35:       begin c.gateMdr = 1; c.ldIr = 1; end
            32:       c.ldBen = 1;
            1, 5, 9:  begin
                c.sr1mux = 1; c.gateAlu = 1; c.ldReg = 1; c.ldCc = 1;
                c.aluk   = (s == 1) ? 2'd0 : (s == 5) ? 2'd1 : 2'd2;
                c.sr2mux = (s == 9) ? 1'b0 : irBit5;
            end
            22:       begin c.addr2mux = 2'd2; c.pcmux = 2'd2; c.ldPc = 1; end
            12, 20:   begin c.sr1mux = 1; c.addr1mux = 1; c.pcmux = 2'd2; c.ldPc = 1; end
            4:        begin c.gatePc = 1; c.dr = 1; c.ldReg = 1; end
            21:       begin c.addr2mux = 2'd3; c.pcmux = 2'd2; c.ldPc = 1; end
            6, 7:     begin c.sr1mux = 1; c.addr1mux = 1; c.addr2mux = 2'd1;
                            c.gateMarmux = 1; c.ldMar = 1; end
            27:       begin c.gateMdr = 1; c.ldReg = 1; c.ldCc = 1; end
            23:       begin c.aluk = 2'd3; c.gateAlu = 1; c.ldMdr = 1; end
            16:       c.memWe = 1;
            100, 101: c.ldLed = 1;
            default:  c = '0;
        endcase
        return c;
    endfunction

    task automatic modelNext(input int k);
        int mw;
        int c;
        mw = (k == 0) ? 2 : 3;
        c  = cur[k];
        if (rst) begin
            while (sizeQ(k) > 0) void'(popQ(k));
            cur[k] = -1;
            return;
        end
        if (sizeQ(k) > 0) begin
            cur[k] = popQ(k);
            return;
        end
        case (c)
            -1: c = run ? 18 : -1;
            18: begin
                repeat (mw) pushQ(k, 33);
                pushQ(k, 35);
                pushQ(k, 32);
                c = popQ(k);
            end
            32: begin
                case (opc)
                    4'd1:  c = 1;
                    4'd5:  c = 5;
                    4'd9:  c = 9;
                    4'd0:  c = 0;
                    4'd12: c = 12;
                    4'd4:  c = 4;
                    4'd6:  begin c = 6; repeat (mw) pushQ(k, 25); pushQ(k, 27); end
                    4'd7:  begin c = 7; pushQ(k, 23); repeat (mw) pushQ(k, 16); end
                    4'd13: c = pauseEnabled() ? 100 : 18;
                    default: c = 18;
                endcase
            end
            0:   c = ben ? 22 : 18;
            4:   c = ir11 ? 21 : 20;
            100: c = cont ? 101 : 100;
            101: c = cont ? 101 : 18;
            default: c = 18;
        endcase
        cur[k] = c;
    endtask

    task automatic checkOutput();
        ctl_t expA, expB;
        expA = expOut(cur[0], ir5);
        expB = expOut(cur[1], ir5);
        checks++;
        assert (obsA === expA) else begin
            errors++;
            $error("[TB] FAIL outA state=%0d observed=%h expected=%h", cur[0], obsA, expA);
        end
        checks++;
        assert (obsB === expB) else begin
            errors++;
            $error("[TB] FAIL outB state=%0d observed=%h expected=%h", cur[1], obsB, expB);
        end
        checks++;
        assert ($countones({obsA.gatePc, obsA.gateMdr, obsA.gateAlu, obsA.gateMarmux}) <= 1) else begin
            errors++;
            $error("[TB] FAIL gateOneHotA observed=%b expected=at most one",
                   {obsA.gatePc, obsA.gateMdr, obsA.gateAlu, obsA.gateMarmux});
        end
    endtask

    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            modelNext(0);
            modelNext(1);
            @(posedge clk);
            #1;
            checkOutput();
        end
    endtask

    initial begin
        cur[0] = -1;
        cur[1] = -1;

        rst = 1'b1;                       applyStimulus(2);
        rst = 1'b0; run = 1'b1;           applyStimulus(1);
        run = 1'b0;                       applyStimulus(1);
        // Reset lands while both instances are in the first fetch wait cycle.
        rst = 1'b1;                       applyStimulus(1);
        rst = 1'b0; run = 1'b1;           applyStimulus(1);
        run = 1'b0; opc = 4'b0001; ir5 = 1'b1; applyStimulus(8);
        opc = 4'b0000; ben = 1'b0;        applyStimulus(8);
        ben = 1'b1;                       applyStimulus(8);
        opc = 4'b0100; ir11 = 1'b1;       applyStimulus(8);
        ir11 = 1'b0;                      applyStimulus(8);
        opc = 4'b0111;                    applyStimulus(12);
        opc = 4'b0110;                    applyStimulus(12);
        opc = 4'b1101; cont = 1'b0;       applyStimulus(8);
        cont = 1'b1;                      applyStimulus(3);
        cont = 1'b0;                      applyStimulus(4);
        opc = 4'b1111;                    applyStimulus(8);

        for (int i = 0; i < 3000; i++) begin
            rst  = ($urandom_range(0, 79) == 0);
            run  = ($urandom_range(0, 3) != 0);
            opc  = 4'($urandom_range(0, 15));
            ir5  = 1'($urandom_range(0, 1));
            ir11 = 1'($urandom_range(0, 1));
            ben  = 1'($urandom_range(0, 1));
            cont = 1'($urandom_range(0, 1));
            applyStimulus(1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
